// File: rtl/cpu_datapath_pkg.sv
// Shared types for the accumulator CPU: opcodes and controller states.
package cpu_datapath_pkg;

    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR,
        INST_FETCH,
        INST_LOAD,
        IDLE,
        OP_ADDR,
        OP_FETCH,
        ALU_OP,
        STORE
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU; is_alu_op flags opcodes that write the AC.
import cpu_datapath_pkg::*;

module cpu_alu #(
    parameter int DWIDTH = 8
) (
    input  opcode_t           opcode,
    input  logic [DWIDTH-1:0] accum,
    input  logic [DWIDTH-1:0] data,
    output logic [DWIDTH-1:0] result,
    output logic              is_alu_op
);

    always_comb begin
        result    = accum;
        is_alu_op = 1'b1;
        unique case (opcode)
            ADD:     result = accum + data;
            AND:     result = accum & data;
            XOR:     result = accum ^ data;
            LDA:     result = data;
            default: is_alu_op = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// PC/IR/AC datapath driven by the instruction controller's strobes.
import cpu_datapath_pkg::*;

module cpu_datapath #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              sel,
    input  logic              load_ac,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              load_ir,
    input  logic              halt,
    input  logic [DWIDTH-1:0] mem_rdata,
    output opcode_t           opcode,
    output logic              zero,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [AWIDTH-1:0] pc,
    output logic              halted
);

    logic [DWIDTH-1:0] ir;
    logic [DWIDTH-1:0] ac;
    logic [DWIDTH-1:0] alu_result;
    logic              is_alu_op;
    logic              ld_ac_q;
    logic              freeze;
    logic              ac_en;

    // The halt cycle itself must already block every register update.
    assign freeze = halted | halt;
    assign ac_en  = load_ac & ~ld_ac_q & is_alu_op & ~freeze;

    assign opcode    = opcode_t'(ir[DWIDTH-1 -: OPCODE_W]);
    assign zero      = (ac == '0);
    assign mem_addr  = sel ? pc : ir[AWIDTH-1:0];
    assign mem_wdata = ac;
    assign mem_re    = mem_rd & ~halted & rst_;
    assign mem_we    = mem_wr & ~halted & rst_;

    cpu_alu #(
        .DWIDTH(DWIDTH)
    ) u_alu (
        .opcode   (opcode),
        .accum    (ac),
        .data     (mem_rdata),
        .result   (alu_result),
        .is_alu_op(is_alu_op)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            halted  <= 1'b0;
            ld_ac_q <= 1'b0;
        end else begin
            ld_ac_q <= load_ac;
            if (halt)
                halted <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ir <= '0;
            ac <= '0;
        end else begin
            if (load_ir && !freeze)
                ir <= mem_rdata;
            if (ac_en)
                ac <= alu_result;
        end
    end

    // A jump wins over a simultaneous increment.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            pc <= '0;
        else if (!freeze) begin
            if (load_pc)
                pc <= ir[AWIDTH-1:0];
            else if (inc_pc)
                pc <= pc + AWIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed test of cpu_datapath against a behavioural CPU model and memory.
import cpu_datapath_pkg::*;

module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       sel = 1'b0;
    logic       load_ac = 1'b0;
    logic       mem_rd = 1'b0;
    logic       mem_wr = 1'b0;
    logic       inc_pc = 1'b0;
    logic       load_pc = 1'b0;
    logic       load_ir = 1'b0;
    logic       halt = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    opcode_t    opcode;
    logic       zero;
    logic [4:0] mem_addr;
    logic       mem_re;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [4:0] pc;
    logic       halted;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [32];

    logic [4:0] m_pc;
    logic [7:0] m_ir;
    logic [7:0] m_ac;
    logic       m_halt;
    logic       m_prev_ld;

    cpu_datapath dut (
        .clk      (clk),
        .rst_     (rst_),
        .sel      (sel),
        .load_ac  (load_ac),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .inc_pc   (inc_pc),
        .load_pc  (load_pc),
        .load_ir  (load_ir),
        .halt     (halt),
        .mem_rdata(mem_rdata),
        .opcode   (opcode),
        .zero     (zero),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .pc       (pc),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Synchronous 32x8 memory: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= mem[mem_addr];
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    // Behavioural model of the architectural state.
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_pc = 0; m_ir = 0; m_ac = 0;
            m_halt = 0; m_prev_ld = 0;
        end else begin
            logic first_ld;
            logic [7:0] nxt_ac;
            first_ld = load_ac && !m_prev_ld;
            m_prev_ld = load_ac;
            if (!m_halt && !halt) begin
                nxt_ac = m_ac;
                case (int'(m_ir[7:5]))
                    2: nxt_ac = 8'((int'(m_ac) + int'(mem_rdata)) % 256);
                    3: nxt_ac = m_ac & mem_rdata;
                    4: nxt_ac = m_ac ^ mem_rdata;
                    5: nxt_ac = mem_rdata;
                    default: nxt_ac = m_ac;
                endcase
                if (load_pc)
                    m_pc = m_ir[4:0];
                else if (inc_pc)
                    m_pc = 5'((int'(m_pc) + 1) % 32);
                if (first_ld)
                    m_ac = nxt_ac;
                if (load_ir)
                    m_ir = mem_rdata;
            end
            if (halt)
                m_halt = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Every cycle out of reset the DUT must agree with the model.
    always @(posedge clk) begin
        #2;
        if (rst_) begin
            chk("pc", 32'(pc), 32'(m_pc));
            chk("opcode", 32'(opcode), 32'(m_ir[7:5]));
            chk("zero", 32'(zero), 32'(m_ac == 0));
            chk("wdata", 32'(mem_wdata), 32'(m_ac));
            chk("addr", 32'(mem_addr), 32'(sel ? m_pc : m_ir[4:0]));
            chk("re", 32'(mem_re), 32'(mem_rd && !m_halt));
            chk("we", 32'(mem_we), 32'(mem_wr && !m_halt));
            chk("halted", 32'(halted), 32'(m_halt));
        end
    end

    task automatic step(input logic s, input logic rd, input logic wr,
                        input logic ldac, input logic inc, input logic ldpc,
                        input logic ldir, input logic hlt);
        @(negedge clk);
        sel = s; mem_rd = rd; mem_wr = wr; load_ac = ldac;
        inc_pc = inc; load_pc = ldpc; load_ir = ldir; halt = hlt;
        @(posedge clk);
        #3;
    endtask

    // One full controller pass; strobes follow the opcode the bench placed.
    task automatic run_instr(input int op);
        logic alu;
        logic is_sto;
        logic is_jmp;
        alu = (op >= 2 && op <= 5);
        is_sto = (op == 6);
        is_jmp = (op == 7);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, op != 0, 0, 0, op == 0);
        if (op == 0)
            return;
        step(0, alu, 0, 0, 0, 0, 0, 0);
        step(0, alu, 0, alu, (op == 1) && (m_ac == 0), is_jmp, 0, 0);
        step(0, alu, is_sto, alu, is_jmp, is_jmp, 0, 0);
        if (is_sto) begin
            chk("sto_we", 32'(mem_we), 32'h1);
            chk("sto_addr", 32'(mem_addr), 32'd23);
            chk("sto_wdata", 32'(mem_wdata), 32'h5A);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_prog_to_9();
        run_instr(5);
        chk("lda_ac", 32'(mem_wdata), 32'hFE);
        chk("lda_pc", 32'(pc), 32'd1);
        run_instr(2);
        chk("add_ac_once", 32'(mem_wdata), 32'h03);
        chk("add_op", 32'(opcode), 32'(ADD));
        chk("add_pc", 32'(pc), 32'd2);
        run_instr(1);
        chk("skz_noskip", 32'(pc), 32'd3);
        run_instr(4);
        chk("xor_ac", 32'(mem_wdata), 32'h06);
        run_instr(3);
        chk("and_zero", 32'(zero), 32'h1);
        run_instr(1);
        chk("skz_skip", 32'(pc), 32'd7);
        run_instr(5);
        chk("lda2_ac", 32'(mem_wdata), 32'h5A);
        run_instr(6);
        chk("sto_mem", 32'(mem[23]), 32'h5A);
        chk("sto_pc", 32'(pc), 32'd9);
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = 8'h00;
        mem[0] = 8'hBE;
        mem[1] = 8'h5D;
        mem[2] = 8'h20;
        mem[3] = 8'h9D;
        mem[4] = 8'h7C;
        mem[5] = 8'h20;
        mem[7] = 8'hBB;
        mem[8] = 8'hD7;
        mem[9] = 8'hFF;
        mem[27] = 8'h5A;
        mem[28] = 8'h00;
        mem[29] = 8'h05;
        mem[30] = 8'hFE;
        mem[31] = 8'h20;

        sel = 1; mem_wr = 1; mem_rd = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_op", 32'(opcode), 32'(HLT));
        chk("rst_zero", 32'(zero), 32'h1);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_re", 32'(mem_re), 32'h0);
        @(negedge clk);
        mem_wr = 0; mem_rd = 0;
        rst_ = 1;

        run_prog_to_9();

        step(0, 0, 0, 0, 1, 0, 0, 1);
        chk("halt_pc", 32'(pc), 32'd9);
        chk("halt_flag", 32'(halted), 32'h1);
        step(1, 1, 1, 1, 1, 1, 1, 0);
        chk("halt_we", 32'(mem_we), 32'h0);
        chk("halt_re", 32'(mem_re), 32'h0);
        step(1, 1, 1, 1, 1, 0, 1, 0);
        chk("halt_pc2", 32'(pc), 32'd9);
        chk("halt_ac", 32'(mem_wdata), 32'h5A);
        chk("halt_op", 32'(opcode), 32'(STO));

        @(negedge clk);
        sel = 0; mem_rd = 0; mem_wr = 0; load_ac = 0;
        inc_pc = 0; load_pc = 0; load_ir = 0; halt = 0;
        rst_ = 0;
        #1;
        chk("rst_halted", 32'(halted), 32'h0);
        @(negedge clk);
        rst_ = 1;

        run_prog_to_9();
        run_instr(7);
        chk("jmp_pc", 32'(pc), 32'd31);
        run_instr(1);
        chk("wrap_pc", 32'(pc), 32'd0);

        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        chk("nonalu_ac", 32'(mem_wdata), 32'h5A);

        @(negedge clk);
        sel = 0; mem_rd = 0; load_ac = 0; mem_wr = 1;
        #1;
        chk("pre_rst_we", 32'(mem_we), 32'h1);
        rst_ = 0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'h0);
        chk("mid_rst_zero", 32'(zero), 32'h1);
        chk("mem0_intact", 32'(mem[0]), 32'hBE);
        mem_wr = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Execution datapath that responds to the 8-state instruction controller's strobes (load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt).
- Returns opcode and zero to the controller.
- Holds the PC, IR and accumulator, selects the memory address, and drives the single-port program/data memory.
- Sits between the controller and the 32x8 memory.

Parameters:
- AWIDTH, 5, memory address width; also the IR operand width.
- DWIDTH, 8, data, IR and accumulator width. The opcode is IR[DWIDTH-1 -: 3].

Ports:
- clk  input  1  system clock, rising-edge active
- rst_  input  1  asynchronous active-low reset
- sel  input  1  address select: 1 = PC (instruction fetch), 0 = IR operand
- load_ac  input  1  accumulator load strobe from controller
- mem_rd  input  1  memory read strobe from controller
- mem_wr  input  1  memory write strobe from controller
- inc_pc  input  1  PC increment strobe
- load_pc  input  1  PC load (jump) strobe
- load_ir  input  1  IR load strobe
- halt  input  1  halt strobe
- mem_rdata  input  DWIDTH  memory read data; valid one cycle after mem_re with a stable mem_addr
- opcode  output  opcode_t  IR[DWIDTH-1 -: 3], to controller
- zero  output  1  1 when accumulator == 0, to controller
- mem_addr  output  AWIDTH  memory address
- mem_re  output  1  memory read enable
- mem_we  output  1  memory write enable
- mem_wdata  output  DWIDTH  write data (the accumulator)
- pc  output  AWIDTH  current PC (debug/verification)
- halted  output  1  sticky halted flag

Behaviour:
- Clock and reset:
  - One clock (clk).
  - rst_ is asynchronous, active-low.
  - In reset: pc=0, ir=0, ac=0, halted=0, ld_ac_q=0.
  - Resulting outputs in reset: opcode=HLT (3'b000), zero=1, mem_re=0, mem_we=0, mem_addr=0.
- Reset asserted mid-instruction clears everything immediately. No partial write survives, because mem_we is forced to 0 combinationally while rst_=0.
- Combinational outputs:
  - mem_addr = sel ? pc : ir[AWIDTH-1:0]
  - opcode = ir[DWIDTH-1 -: 3]
  - zero = (ac == 0)
  - mem_wdata = ac
  - mem_re = mem_rd & ~halted
  - mem_we = mem_wr & ~halted
- IR: on a posedge with load_ir=1 and halted=0, ir <= mem_rdata. The controller holds load_ir for two cycles (INST_LOAD, IDLE); the second load is idempotent.
- Accumulator (edge-qualified):
  - ld_ac_q registers load_ac.
  - ac updates only when load_ac & ~ld_ac_q & ~halted, i.e. the first cycle of a load_ac burst. The STORE-cycle repeat therefore never double-applies ADD.
  - ALU result by opcode:
    - ADD: (ac + mem_rdata) mod 2^DWIDTH; carry discarded.
    - AND: ac & mem_rdata.
    - XOR: ac ^ mem_rdata.
    - LDA: mem_rdata.
    - Any other opcode: ac unchanged, even if load_ac is asserted.
- PC priority per edge, highest first:
  1. halted: hold.
  2. load_pc: pc <= ir[AWIDTH-1:0].
  3. inc_pc: pc <= pc + 1, wrapping 2^AWIDTH-1 -> 0.
  4. Otherwise hold.
- load_pc and inc_pc together (JMP in STORE) give the load target, not target+1.
- SKZ: a single inc_pc in ALU_OP skips one word. The datapath does not check zero itself; it only obeys inc_pc.
- Halt:
  - halt=1 at a posedge sets halted=1.
  - The halt cycle itself already suppresses any pc/ir/ac update.
  - halted is sticky until rst_.
  - While halted: mem_re=mem_we=0 and all registers frozen. opcode and zero continue to reflect frozen state.
- Write timing: mem_we may be asserted on the same cycle as mem_rd deassertion. No read and write is ever issued to the same address in one cycle, because the controller excludes it. If both arrive anyway, both enables are driven as given and memory behaviour is the memory's contract.

Decomposition:
- Shared package typedefs:
  - opcode_t: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - state_t is already present.
  - Add constant OPCODE_W=3.
- One sub-module, cpu_alu:
  - Purely combinational.
  - Inputs: opcode, accum, data. Outputs: result, is_alu_op.
  - Instantiated once.
  - Register, PC and halt logic stay in cpu_datapath.

Test Plan:
- Reset release. Hold rst_=0, then release with sel=1 -> pc=0, mem_addr=0, opcode=HLT, zero=1, mem_we=0. Assert rst_=0 mid-STORE with mem_wr=1 -> mem_we=0 the same cycle.
- Fetch and ADD.
  - Stimulus: mem[0]=8'h42 (ADD, operand 2), mem[2]=8'h05, ac=8'hFE. Run the full 8-state sequence.
  - Result: ir=8'h42, ac=8'h03 (wrapped), applied exactly once despite the 2-cycle load_ac; pc=1.
- JMP.
  - Stimulus: ir=8'hFC (JMP 28); load_pc in ALU_OP and STORE, plus inc_pc in STORE.
  - Result: pc=28 (not 29).
- SKZ and wrap.
  - ac=0, pc=4, inc_pc in IDLE and ALU_OP -> pc=6.
  - pc=31 with one inc_pc -> pc=0.
- STO. ac=8'h5A, ir=8'hD7 (STO 23), mem_wr in STORE -> mem_we=1, mem_addr=23, mem_wdata=8'h5A for that cycle only.
- Halt.
  - Stimulus: halt pulse with simultaneous inc_pc at pc=9.
  - Result: pc stays 9, halted=1. Later load_ir, load_ac and mem_wr strobes change nothing and mem_we=0.
  - Release: rst_ low clears halted.
